serial_addsub_ctrl: RTL and testbench

//  Sequences one shared 4-bit add/subtract slice over WIDTH-bit operands, one nibble per clock,
//  LSB nibble first, with a registered inter-nibble carry. Start/ready/done handshake for a host FSM.

---
 rtl/addsub_pkg.sv | 10 +
 rtl/addsub_slice4.sv | 25 ++
 rtl/serial_addsub_ctrl.sv | 116 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the nibble-serial add/subtract controller and its 4-bit slice.
package addsub_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/addsub_slice4.sv
// Combinational 4-bit ripple adder slice; also exposes the carry into bit 3 for overflow.
module addsub_slice4
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                c3,
   output logic                cout
);
   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   generate
      for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
         assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
      end
   endgenerate

   assign c3   = c[NIBBLE_W-1];
   assign cout = c[NIBBLE_W];
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Runs WIDTH-bit add/sub through one shared 4-bit slice, LSB nibble first, one nibble per clock.
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);
   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = $clog2(NIBBLES);

   state_e                state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg;
   logic [WIDTH-1:0]      x_reg, y_reg;
   logic                  sub_reg, carry_reg;
   logic [NIBBLE_W-1:0]   res_nib_reg [NIBBLES];
   logic                  carry_out_reg, overflow_reg;

   logic [NIBBLE_W-1:0]   x_nib [NIBBLES];
   logic [NIBBLE_W-1:0]   y_nib [NIBBLES];
   logic [NIBBLE_W-1:0]   slice_a, slice_b, slice_s;
   logic                  slice_c3, slice_cout;
   logic                  last_nib;

   generate
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign x_nib[gi] = x_reg[gi*NIBBLE_W +: NIBBLE_W];
         assign y_nib[gi] = y_reg[gi*NIBBLE_W +: NIBBLE_W];
         assign result[gi*NIBBLE_W +: NIBBLE_W] = res_nib_reg[gi];
      end
   endgenerate

   // Subtraction inverts B here so the slice's carry-in is just the registered carry.
   assign slice_a  = x_nib[cnt_reg];
   assign slice_b  = y_nib[cnt_reg] ^ {NIBBLE_W{sub_reg}};
   assign last_nib = (cnt_reg == CNT_W'(NIBBLES - 1));

   addsub_slice4 u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg),
      .s    (slice_s),
      .c3   (slice_c3),
      .cout (slice_cout)
   );

   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_nib) state_next = ST_DONE;
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         x_reg         <= '0;
         y_reg         <= '0;
         sub_reg       <= 1'b0;
         carry_reg     <= 1'b0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         for (int i = 0; i < NIBBLES; i++) res_nib_reg[i] <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && start) begin
            x_reg     <= x;
            y_reg     <= y;
            sub_reg   <= sub;
            carry_reg <= sub;
            cnt_reg   <= '0;
         end else if (state_reg == ST_RUN) begin
            res_nib_reg[cnt_reg] <= slice_s;
            carry_reg            <= slice_cout;
            if (last_nib) begin
               cnt_reg       <= '0;
               carry_out_reg <= slice_cout;
               overflow_reg  <= slice_c3 ^ slice_cout;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
      end
   end

   assign carry_out = carry_out_reg;
   assign overflow  = overflow_reg;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed-vector bench for serial_addsub_ctrl at WIDTH=16 (four nibble cycles per operation).
module tb_serial_addsub_ctrl;
   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             sub = 1'b0;
   logic [WIDTH-1:0] x = '0;
   logic [WIDTH-1:0] y = '0;
   logic             ready, busy, done, carry_out, overflow;
   logic [WIDTH-1:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             sub;
      logic [WIDTH-1:0] r;
      logic             c;
      logic             v;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .x         (x),
      .y         (y),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive a request and return #1 after the accepting edge E0.
   task automatic start_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv, input logic sv);
      @(negedge clk);
      x = xv; y = yv; sub = sv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count edges after E0 until done is seen, bounded.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   initial begin
      int lat;
      vecs[0] = '{"add_basic",   16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{"add_ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{"sub_equal",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{"sub_zero_m1", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[7] = '{"add_negneg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

      // Reset state
      #12;
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_ready", 32'(ready), 32'h1);

      // Table-driven operations
      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].x, vecs[i].y, vecs[i].sub);
         chk({vecs[i].name, "_busy_e0"}, 32'(busy), 32'h1);
         wait_done(lat);
         chk({vecs[i].name, "_latency"}, 32'(lat), 32'd4);
         chk({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].r));
         chk({vecs[i].name, "_carry"}, 32'(carry_out), 32'(vecs[i].c));
         chk({vecs[i].name, "_ovf"}, 32'(overflow), 32'(vecs[i].v));
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_done_1cyc"}, 32'(done), 32'h0);
         chk({vecs[i].name, "_ready_after"}, 32'(ready), 32'h1);
         chk({vecs[i].name, "_hold"}, 32'(result), 32'(vecs[i].r));
         $display("op %s x=%h y=%h sub=%0d -> result=%h c=%0d v=%0d lat=%0d",
                  vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].sub, result, carry_out, overflow, lat);
      end

      // Async reset mid-run: flags are 1/1 from the previous op
      start_op(16'h1234, 16'h1111, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_result", 32'(result), 32'h0);
      chk("arst_carry", 32'(carry_out), 32'h0);
      chk("arst_ovf", 32'(overflow), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("arst_ready", 32'(ready), 32'h1);
      begin
         int seen_done = 0;
         for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 if (done || busy) seen_done++;
         end
         chk("arst_no_done", 32'(seen_done), 32'h0);
      end
      start_op(16'h0F0F, 16'h00F1, 1'b0);
      wait_done(lat);
      chk("arst_fresh_lat", 32'(lat), 32'd4);
      chk("arst_fresh_result", 32'(result), 32'h1000);
      $display("op arst_fresh x=0f0f y=00f1 sub=0 -> result=%h lat=%0d", result, lat);
      @(posedge clk);
      #1;

      // Start ignored while running; inputs change after E0
      start_op(16'h1111, 16'h2222, 1'b0);
      chk("busy_ready_e0", 32'(ready), 32'h0);
      @(negedge clk);
      start = 1'b1; x = 16'hFFFF; y = 16'hFFFF; sub = 1'b1;
      begin
         int ready_hi = 0;
         lat = 0;
         while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (ready) ready_hi++;
            if (lat == 2) start = 1'b0;
         end
         start = 1'b0;
         chk("busy_ready_run", 32'(ready_hi), 32'h0);
      end
      chk("busy_latency", 32'(lat), 32'd4);
      chk("busy_result", 32'(result), 32'h3333);
      chk("busy_carry", 32'(carry_out), 32'h0);
      @(posedge clk);
      #1;
      chk("busy_ready_after", 32'(ready), 32'h1);
      chk("busy_idle", 32'(busy), 32'h0);
      $display("op ignored_start x=1111 y=2222 sub=0 -> result=%h lat=%0d", result, lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
